// File: rtl/seg_disp_sched.sv
// seg_disp_sched
//   Time-shares the 8-digit serial 7-seg display path among NSRC 32-bit debug
//   sources. Each refresh it picks a source (auto round-robin or manual select),
//   latches the value, pulses p2s_start to the serial shifter, and holds the
//   value steady until the shift is done and REFRESH idle cycles have passed.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   src_data     NSRC packed 32-bit sources, source i at [32*i+31:32*i]
//   src_valid    per-source eligibility
//   mode         0 = auto round-robin, 1 = manual
//   sel_manual   manual source index (out of range maps to 0)
//   next_btn     one-cycle pulse: advance to next valid source (auto mode)
//   p2s_busy     shifter busy, high while shifting
//   p2s_start    one-cycle start pulse to the shifter
//   p2s_num      value being displayed
//   dot          one-hot source indicator, dot[cur_src[2:0]]
//   cur_src      index of the latched source
//   to_err       sticky: shifter never acknowledged a start
//
// Handshake: p2s_start is high for exactly one cycle (the START state). The
// shifter acknowledges by raising p2s_busy within BUSY_TO cycles and completes
// by dropping it; busy is only looked at in WAIT_ACK and WAIT_DONE.
// The FSM state is held in state_q.

module seg_disp_sched #(
  parameter int NSRC    = 4,
  parameter int DWELL   = 2**24,
  parameter int REFRESH = 2**16,
  parameter int BUSY_TO = 8,
  localparam int IDXW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC*32-1:0]   src_data,
  input  logic [NSRC-1:0]      src_valid,
  input  logic                 mode,
  input  logic [IDXW-1:0]      sel_manual,
  input  logic                 next_btn,
  input  logic                 p2s_busy,
  output logic                 p2s_start,
  output logic [31:0]          p2s_num,
  output logic [7:0]           dot,
  output logic [IDXW-1:0]      cur_src,
  output logic                 to_err
);

  localparam int DW = $clog2(DWELL + 1);
  localparam int RW = $clog2(REFRESH + 1);
  localparam int AW = $clog2(BUSY_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_ACK, S_WAIT_DONE, S_HOLD
  } state_e;

  state_e            state_q;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic              adv_pend_q, adv_pend_d;
  logic [AW-1:0]     ack_q;
  logic [RW-1:0]     refresh_q;
  logic              p2s_start_q;
  logic [31:0]       p2s_num_q;
  logic [7:0]        dot_q;
  logic [IDXW-1:0]   cur_src_q;
  logic              to_err_q;

  logic [31:0]       words [NSRC];
  logic [IDXW-1:0]   man_idx, nxt_idx, load_idx, cand;
  logic              found, dwell_exp;
  logic [31:0]       load_data;
  logic [2:0]        dot_sel;

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      words[i] = src_data[32*i +: 32];
    end
  end

  // Source selection, only consumed in LOAD.
  always_comb begin
    man_idx = (32'(sel_manual) >= 32'(NSRC)) ? '0 : sel_manual;
    // First valid index after cur_src, wrapping; the last candidate is cur_src
    // itself, and if nothing is valid the index stays put.
    nxt_idx = cur_src_q;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NSRC; k++) begin
      cand = IDXW'((int'(cur_src_q) + k) % NSRC);
      if (!found && src_valid[cand]) begin
        nxt_idx = cand;
        found   = 1'b1;
      end
    end
    load_idx  = mode ? man_idx : (adv_pend_q ? nxt_idx : cur_src_q);
    load_data = src_valid[load_idx] ? words[load_idx] : 32'h0;
    dot_sel   = 3'(load_idx);
  end

  // Dwell counter runs only in auto mode. A new advance request in the LOAD
  // cycle itself wins over the clear so it is not lost.
  always_comb begin
    dwell_exp  = !mode && (dwell_q == DW'(DWELL - 1));
    dwell_d    = (mode || dwell_exp) ? '0 : dwell_q + DW'(1);
    adv_pend_d = ((state_q == S_LOAD) ? 1'b0 : adv_pend_q)
               | (!mode && (dwell_exp || next_btn));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dwell_q     <= '0;
      adv_pend_q  <= 1'b0;
      ack_q       <= '0;
      refresh_q   <= '0;
      p2s_start_q <= 1'b0;
      p2s_num_q   <= 32'h0;
      dot_q       <= 8'h01;
      cur_src_q   <= '0;
      to_err_q    <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      adv_pend_q  <= adv_pend_d;
      p2s_start_q <= 1'b0;
      case (state_q)
        S_IDLE: state_q <= S_LOAD;
        S_LOAD: begin
          p2s_num_q   <= load_data;
          cur_src_q   <= load_idx;
          dot_q       <= 8'b1 << dot_sel;
          p2s_start_q <= 1'b1;
          state_q     <= S_START;
        end
        S_START: begin
          ack_q   <= '0;
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (p2s_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (ack_q == AW'(BUSY_TO - 1)) begin
            to_err_q  <= 1'b1;
            refresh_q <= '0;
            state_q   <= S_HOLD;
          end else begin
            ack_q <= ack_q + AW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!p2s_busy) begin
            refresh_q <= '0;
            state_q   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (refresh_q == RW'(REFRESH - 1)) begin
            state_q <= S_LOAD;
          end else begin
            refresh_q <= refresh_q + RW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign p2s_start = p2s_start_q;
  assign p2s_num   = p2s_num_q;
  assign dot       = dot_q;
  assign cur_src   = cur_src_q;
  assign to_err    = to_err_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched
//   Drives seg_disp_sched (NSRC=4) against a behavioural model that predicts,
//   from the display rules, when each start pulse happens and what value and
//   index get latched. A second instance (NSRC=5, dead shifter) covers
//   out-of-range manual selection.

module tb_seg_disp_sched;

  localparam int NSRC     = 4;
  localparam int DWELL    = 100;
  localparam int REFRESH  = 16;
  localparam int BUSY_TO  = 8;
  localparam int BUSY_LEN = 70;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT 1
  logic [NSRC*32-1:0] src_data = '0;
  logic [NSRC-1:0]    src_valid = '0;
  logic               mode = 1'b0;
  logic [1:0]         sel_manual = '0;
  logic               next_btn = 1'b0;
  logic               p2s_busy = 1'b0;
  logic               p2s_start;
  logic [31:0]        p2s_num;
  logic [7:0]         dot;
  logic [1:0]         cur_src;
  logic               to_err;

  seg_disp_sched #(.NSRC(NSRC), .DWELL(DWELL), .REFRESH(REFRESH), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid), .mode(mode),
    .sel_manual(sel_manual), .next_btn(next_btn), .p2s_busy(p2s_busy),
    .p2s_start(p2s_start), .p2s_num(p2s_num), .dot(dot), .cur_src(cur_src), .to_err(to_err)
  );

  // DUT 2: five sources, manual, shifter never answers
  logic [159:0] src_data2;
  logic [2:0]   sel2 = '0;
  logic         p2s_start2, to_err2;
  logic [31:0]  p2s_num2;
  logic [7:0]   dot2;
  logic [2:0]   cur_src2;

  seg_disp_sched #(.NSRC(5), .DWELL(DWELL), .REFRESH(REFRESH), .BUSY_TO(BUSY_TO)) dut2 (
    .clk(clk), .rst(rst), .src_data(src_data2), .src_valid(5'h1f), .mode(1'b1),
    .sel_manual(sel2), .next_btn(1'b0), .p2s_busy(1'b0),
    .p2s_start(p2s_start2), .p2s_num(p2s_num2), .dot(dot2), .cur_src(cur_src2), .to_err(to_err2)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int          cyc = 0;
  int          next_start = -1;
  int          last_start = -1;
  int          err_at = -1;
  int          busy_from = -10;
  int          busy_until = -10;
  bit          dead = 1'b0;
  int          m_cur = 0;
  int          m_dwell = 0;
  bit          m_pend = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_num = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit busy_at(input int c);
    return (c >= busy_from) && (c <= busy_until);
  endfunction

  task automatic model_reset();
    m_cur = 0; m_num = '0; m_pend = 1'b0; m_dwell = 0; m_err = 1'b0;
    next_start = -1; err_at = -1;
  endtask

  // Which source is shown next and its value, from the selection rules.
  task automatic do_load();
    int idx;
    idx = m_cur;
    if (mode) begin
      idx = (int'(sel_manual) >= NSRC) ? 0 : int'(sel_manual);
    end else if (m_pend) begin
      for (int k = NSRC; k >= 1; k--) begin
        if (src_valid[(m_cur + k) % NSRC]) idx = (m_cur + k) % NSRC;
      end
    end
    m_cur  = idx;
    m_num  = src_valid[idx] ? src_data[idx*32 +: 32] : 32'h0;
    m_pend = 1'b0;
  endtask

  // Start at cycle s: shifter takes it if idle; predict ack/done and the next start.
  task automatic predict(input int s);
    int a, d;
    if (!dead && busy_until <= s) begin
      busy_from = s + 1; busy_until = s + BUSY_LEN;
    end
    a = -1;
    for (int c = s + 1; c <= s + BUSY_TO; c++) if (a < 0 && busy_at(c)) a = c;
    if (a < 0) begin
      err_at = s + BUSY_TO + 1;
      next_start = s + BUSY_TO + 2 + REFRESH;
    end else begin
      d = a + 1;
      while (busy_at(d)) d++;
      next_start = d + 2 + REFRESH;
    end
  endtask

  task automatic check_outputs(input bit exp_start);
    check("start", {31'b0, p2s_start}, {31'b0, exp_start});
    check("num",   p2s_num, m_num);
    check("cur",   32'(cur_src), 32'(m_cur));
    check("dot",   32'(dot), 32'(8'b1 << m_cur));
    check("to_err", {31'b0, to_err}, {31'b0, m_err});
  endtask

  // one clock: advance model for this edge, compare, drive shifter busy
  task automatic tick();
    bit exp_start;
    @(posedge clk); #1; cyc++;
    exp_start = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (cyc == err_at) m_err = 1'b1;
      if (cyc == next_start) begin
        exp_start = 1'b1;
        do_load();
        predict(cyc);
        last_start = cyc;
      end
      if (!mode) begin
        m_dwell++;
        if (m_dwell == DWELL) begin m_dwell = 0; m_pend = 1'b1; end
        if (next_btn) m_pend = 1'b1;
      end else begin
        m_dwell = 0;
      end
    end
    check_outputs(exp_start);
    p2s_busy = busy_at(cyc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int  first;
    bit  hit;
    for (int i = 0; i < 5; i++) src_data2[32*i +: 32] = 32'hA000_0000 + i;

    // reset and first display: src0 only
    src_data[31:0] = 32'h8000_0000;
    src_valid = 4'b0001;
    run(3);
    rst = 1'b0;
    next_start = cyc + 2;
    run(200);

    // auto round-robin over all sources with fixed data
    src_valid = 4'b1111;
    for (int i = 0; i < NSRC; i++) src_data[32*i +: 32] = 32'h1111_1111 * (i + 1);
    run(500);
    for (int i = 0; i < 300; i++) begin
      src_data = {$urandom, $urandom, $urandom, $urandom};
      next_btn = ($urandom_range(0, 19) == 0);
      tick();
    end
    next_btn = 1'b0;

    // sparse valid, then nothing valid
    src_valid = 4'b1001;
    run(400);
    src_valid = 4'b0000;
    run(200);

    // manual select 2 with button pulses
    src_valid = 4'b1111;
    mode = 1'b1;
    sel_manual = 2'd2;
    for (int i = 0; i < 400; i++) begin
      next_btn = ($urandom_range(0, 9) == 0);
      tick();
    end
    next_btn = 1'b0;
    check("manual_hold", 32'(cur_src), 32'd2);

    // dead shifter: timeout sets to_err, starts keep coming
    mode = 1'b0;
    dead = 1'b1;
    run(200);
    check("to_err_set", {31'b0, to_err}, 32'd1);
    dead = 1'b0;

    // reset in the middle of a shift (WAIT_DONE)
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      hit = (cyc == last_start + 20) && busy_at(cyc);
    end
    check("reach_wait_done", {31'b0, hit}, 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(1'b0);
    run(3);
    rst = 1'b0;
    next_start = cyc + 2;
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (p2s_start && first == 0) first = k;
    end
    check("first_start_after_rst", 32'(first), 32'd2);
    run(150);

    // randomized mix
    for (int i = 0; i < 1200; i++) begin
      if (i % 60 == 0) mode = 1'($urandom_range(0, 1));
      if (i % 97 == 0) src_valid = 4'($urandom_range(0, 15));
      if (i % 40 == 0) sel_manual = 2'($urandom_range(0, 3));
      src_data = {$urandom, $urandom, $urandom, $urandom};
      next_btn = ($urandom_range(0, 15) == 0);
      tick();
    end
    next_btn = 1'b0;

    // five-source instance: out-of-range manual index maps to 0
    sel2 = 3'd3; run(60);
    check("m5_cur_3", 32'(cur_src2), 32'd3);
    check("m5_num_3", p2s_num2, 32'hA000_0003);
    check("m5_dot_3", 32'(dot2), 32'h08);
    sel2 = 3'd5; run(60);
    check("m5_cur_5", 32'(cur_src2), 32'd0);
    check("m5_num_5", p2s_num2, 32'hA000_0000);
    check("m5_dot_5", 32'(dot2), 32'h01);
    sel2 = 3'd4; run(60);
    check("m5_cur_4", 32'(cur_src2), 32'd4);
    check("m5_dot_4", 32'(dot2), 32'h10);
    sel2 = 3'd7; run(60);
    check("m5_cur_7", 32'(cur_src2), 32'd0);
    check("m5_err", {31'b0, to_err2}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
